// File: rtl/ifu_pkg.sv
// ifu_pkg: fetch-stage entry type, NOP encoding and RV32 opcodes shared with the main decoder
package ifu_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO of fetch entries with flush; head is presented combinationally
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic [CW-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || pop_i);

    // pointers and occupancy; flush empties the buffer and wins over push/pop
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= do_pop ? nxt(rd_q) : rd_q;
            wr_q  <= do_push ? nxt(wr_q) : wr_q;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // entry storage; contents are only observed through a non-zero count so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: imem fetch with in-flight cap, response buffer and redirect flush (IFU_PERF_CNT_EN adds counters)
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] discard_cnt_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, fifo_count;
    logic fifo_empty, fifo_full, grant, rvalid, push, pop;
    fetch_entry_t head;

    assign target        = redirect_pc_i & ~32'h3;
    assign imem_req_o    = rst_n && !redirect_i &&
                           (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr_o   = fetch_pc_q;
    assign grant         = imem_req_o && imem_gnt_i;
    assign rvalid        = imem_rvalid_i && (outstanding_q != '0);
    assign push          = rvalid && (discard_q == '0) && !redirect_i;
    assign instr_valid_o = !fifo_empty && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = fifo_empty ? NOP_INSTR : head.instr;
    assign instr_pc_o    = fifo_empty ? 32'h0 : head.pc;
    assign opcode_o      = instr_o[6:0];
    assign funct3_o      = instr_o[14:12];

    ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_i  ('{pc: resp_pc_q, instr: imem_rdata_i}),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // next fetch/response PCs and in-flight bookkeeping; a redirect marks every surviving request stale
    always_comb begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(rvalid);
        fetch_pc_d    = redirect_i ? target : fetch_pc_q + (grant ? 32'd4 : 32'd0);
        resp_pc_d     = redirect_i ? target : resp_pc_q + (push ? 32'd4 : 32'd0);
        discard_d     = redirect_i ? outstanding_d : discard_q - CW'(rvalid && discard_q != '0);
    end

    // fetch state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid_i && outstanding_q == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, discard_cnt_q;
    logic drop;

    assign drop          = rvalid && (discard_q != '0 || redirect_i);
    assign fetch_cnt_o   = fetch_cnt_q;
    assign discard_cnt_o = discard_cnt_q;

    // saturating counts of instructions handed to decode and responses thrown away
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_cnt_q   <= fetch_cnt_q + 32'(pop && fetch_cnt_q != '1);
            discard_cnt_q <= discard_cnt_q + 32'(drop && discard_cnt_q != '1);
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random imem/decode traffic against a transaction-level model of the fetch stage
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam int DEPTH = 2;

    logic clk = 1'b0, rst_n = 1'b0, redirect_i = 1'b0, imem_gnt_i = 1'b0;
    logic imem_rvalid_i = 1'b0, instr_ready_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
    logic imem_req_o, instr_valid_o;
    logic [31:0] imem_addr_o, instr_o, instr_pc_o;
    logic [6:0] opcode_o;
    logic [2:0] funct3_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_o, discard_cnt_o;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .opcode_o      (opcode_o),
`ifdef IFU_PERF_CNT_EN
        .fetch_cnt_o   (fetch_cnt_o),
        .discard_cnt_o (discard_cnt_o),
`endif
        .funct3_o      (funct3_o)
    );

    // memory transaction: address, earliest response cycle, redirect epoch it was issued in
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } txn_t;

    txn_t        mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] exp_fetch = RPC;
    int epoch = 0, cyc = 0, n_chk = 0, n_fail = 0, n_pop = 0, n_drop = 0;
    int gnt_pct = 100, lat_min = 1, lat_max = 1;
    bit rst_seen = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: drive at negedge, check #1 later, advance the model at posedge
    task automatic step();
        logic exp_req, exp_valid;
        logic [31:0] exp_i;
        txn_t t;
        imem_gnt_i    = $urandom_range(99) < gnt_pct;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (rst_n && mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(mem_q[0].addr);
            end
        end
        exp_req   = !redirect_i && (mem_q.size() + buf_q.size()) < DEPTH;
        exp_valid = !redirect_i && buf_q.size() > 0;
        #1;
        if (rst_n) begin
            chk("req", imem_req_o, exp_req);
            if (exp_req) chk("addr", imem_addr_o, exp_fetch);
            chk("valid", instr_valid_o, exp_valid);
            if (!redirect_i) begin
                exp_i = buf_q.size() > 0 ? mem_word(buf_q[0]) : NOP_INSTR;
                chk("pc", instr_pc_o, buf_q.size() > 0 ? buf_q[0] : 32'h0);
                chk("instr", instr_o, exp_i);
                chk("opcode", opcode_o, exp_i[6:0]);
                chk("funct3", funct3_o, exp_i[14:12]);
            end
`ifdef IFU_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt_o, n_pop);
            chk("discard_cnt", discard_cnt_o, n_drop);
`endif
        end else if (rst_seen) begin
            chk("rst_req", imem_req_o, 1'b0);
            chk("rst_valid", instr_valid_o, 1'b0);
            chk("rst_instr", instr_o, NOP_INSTR);
            chk("rst_pc", instr_pc_o, 32'h0);
            chk("rst_addr", imem_addr_o, RPC);
        end
        @(posedge clk);
        if (!rst_n) begin
            mem_q.delete();
            buf_q.delete();
            exp_fetch = RPC;
            n_pop     = 0;
            n_drop    = 0;
            rst_seen  = 1'b1;
        end else begin
            if (exp_valid && instr_ready_i) begin
                void'(buf_q.pop_front());
                n_pop++;
            end
            if (imem_rvalid_i) begin
                t = mem_q.pop_front();
                if (t.epoch == epoch && !redirect_i) buf_q.push_back(t.addr);
                else n_drop++;
            end
            if (exp_req && imem_gnt_i) begin
                mem_q.push_back('{exp_fetch, cyc + int'($urandom_range(lat_max, lat_min)), epoch});
                exp_fetch += 32'd4;
            end
            if (redirect_i) begin
                epoch++;
                buf_q.delete();
                exp_fetch = redirect_pc_i & ~32'h3;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int k;
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        instr_ready_i = 1'b1;
        repeat (20) step();
        instr_ready_i = 1'b0;
        repeat (8) step();
        chk("bp_req_low", imem_req_o, 1'b0);
        chk("bp_valid_high", instr_valid_o, 1'b1);
        instr_ready_i = 1'b1;
        repeat (10) step();
        lat_min = 3;
        lat_max = 3;
        k = 0;
        while (!(mem_q.size() == 2 && buf_q.size() == 0) && k < 20) begin
            step();
            k++;
        end
        chk("setup_two_outstanding", k < 20, 1'b1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        step();
        redirect_i = 1'b0;
        chk("redir_addr", imem_addr_o, 32'h0000_0100);
        k = 0;
        while (buf_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        chk("redir_first_pc", instr_pc_o, 32'h0000_0100);
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 0;
        repeat (3) step();
        gnt_pct = 100;
        repeat (6) step();
        gnt_pct = 60;
        lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            instr_ready_i = $urandom_range(3) != 0;
            redirect_i = $urandom_range(29) == 0;
            redirect_pc_i = $urandom;
            step();
            redirect_i = 1'b0;
        end
        rst_seen = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        gnt_pct = 100;
        lat_max = 1;
        instr_ready_i = 1'b1;
        repeat (12) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
